core_id_dc_stage: RTL and testbench
===================================

Name: core_id_dc_stage

Overview:
- Registered, parametrised RV32I decode stage between IF and EX, with valid/ready handshake on both sides and a DEPTH-entry decoded-instruction queue.
- Each accepted instruction is decoded once into these fields: opcode class, register indices, funct3, sign-extended immediate, mret flag and illegal flag. The result is queued with its PC.
- A flush port discards everything in flight for branch and trap redirects.

Parameters:
- DEPTH, 2, queue entries; power of two, >=2.
- PC_W, 32, PC width carried alongside each instruction.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all queued entries and any same-cycle push.
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  stage can accept.
- in_istr  in  32  raw instruction.
- in_pc  in  PC_W  instruction PC.
- out_valid  out  1  queue head valid.
- out_ready  in  1  EX consumes head.
- out_pc  out  PC_W  head PC.
- out_cls  out  11  one-hot class; bits 0..10 = ra, ia, ld, sd, br, jr, j, lui, auipc, fence, sys.
- out_funct3  out  3  istr[14:12].
- out_rd  out  5  istr[11:7]; forced 0 for sd and br.
- out_rs1  out  5  istr[19:15].
- out_rs2  out  5  istr[24:20].
- out_imm  out  32  immediate, sign-extended per format.
- out_mret  out  1  istr == 0x30200073.
- out_illegal  out  1  undecodable instruction.
- out_count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (rst=1 at clk edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, in_ready=1, out_count=0.
  - All data outputs read as 0 while out_valid=0 (outputs masked).
- Push: in_valid && in_ready && !flush. Decode is combinational on in_istr; the entry is written at wr_ptr at the clk edge.
- Pop: out_valid && out_ready && !flush. rd_ptr advances.
- Occupancy and flow control:
  - in_ready = (count != DEPTH).
  - No push-through when full, even if out_ready is high in the same cycle.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- Latency: an instruction accepted at edge N appears at the head at edge N at the earliest. out_valid is asserted in cycle N+1 (one-cycle decode latency).
- Head stability: while out_valid && !out_ready, all out_* fields are held stable.
- Pointers: wrap modulo DEPTH.
- Flush:
  - At the next edge: count=0, pointers=0, out_valid=0.
  - A same-cycle push or pop is ignored.
  - flush has priority over everything except rst.
- Class decode: istr[6:2] maps as ra=01100, ia=00100, ld=00000, sd=01000, br=11000, jr=11001, j=11011, lui=01101, auipc=00101, fence=00011, sys=11100. Any other value gives out_cls=0.
- Immediate by format:
  - I (ia, ld, jr, sys): sext(istr[31:20]).
  - S (sd): sext({istr[31:25], istr[11:7]}).
  - B (br): sext({istr[31], istr[7], istr[30:25], istr[11:8], 1'b0}).
  - U (lui, auipc): {istr[31:12], 12'h0}.
  - J (j): sext({istr[31], istr[19:12], istr[20], istr[30:21], 1'b0}).
  - ra and fence: 0.

Optional Feature:
- Macro: CORE_ID_DC_ILLEGAL_CHK_EN.
- When defined, out_illegal=1 for any of the following:
  - istr[1:0] != 2'b11.
  - Unknown opcode (out_cls=0).
  - ra with funct7 not in {0000000, 0100000}.
  - ra with funct7=0100000 and funct3 not in {000, 101}.
  - slli with istr[31:25] != 0.
  - srli/srai with istr[31:25] not in {0000000, 0100000}.
  - ld with funct3 in {011, 110, 111}.
  - sd with funct3 >= 011.
  - br with funct3 in {010, 011}.
  - jr with funct3 != 000.
  - sys with funct3 = 100.
- An illegal entry is still queued and popped normally; EX raises the trap.
- When not defined: out_illegal is tied 0 and no check logic is generated.

Test Plan:
- After reset, push 0x00500093 @pc 0x100 (addi x1,x0,5) -> next cycle out_valid=1, out_cls=bit1 (ia), rd=1, rs1=0, imm=0x00000005, pc=0x100, illegal=0.
- Push 0x0020A423 (sw x2,8(x1)) then 0xFE000EE3 (beq x0,x0,-4) -> first entry: cls sd, rd=0, rs1=1, rs2=2, imm=0x00000008. Second entry: cls br, funct3=0, imm=0xFFFFFFFC.
- Hold out_ready=0 and push DEPTH=2 instructions -> in_ready=0, out_count=2. A third in_valid is not accepted. Raise out_ready for one cycle -> count=1, in_ready=1; head fields stayed unchanged while stalled.
- Queue 2 entries, assert flush together with in_valid=1 -> next cycle out_valid=0, out_count=0. The flushed-cycle instruction never appears.
- Push 0x30200073 -> out_mret=1, cls sys. Push 0x002081B3 (add) -> cls ra, rd=3, rs1=1, rs2=2, mret=0.
- With CORE_ID_DC_ILLEGAL_CHK_EN defined, push 0x0000007F and 0x402091B3 (funct7=0100000, funct3=001) -> out_illegal=1 for both. Without the macro, out_illegal=0.

Source files
------------

// File: rtl/core_id_dc_stage.sv
// core_id_dc_stage: registered RV32I decode stage between IF and EX.
// Each accepted instruction is decoded once and then queued, with its PC, in a
// DEPTH-entry queue. Both sides use a valid/ready handshake. A flush discards
// every entry in flight.
// Optional build macro: CORE_ID_DC_ILLEGAL_CHK_EN enables illegal-instruction
// detection. Without it, out_illegal is tied to 0.
module core_id_dc_stage #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_istr,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [10:0]                out_cls,
    output logic [2:0]                 out_funct3,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [31:0]                out_imm,
    output logic                       out_mret,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     out_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // One-hot class bit positions
    localparam int CLS_RA    = 0;
    localparam int CLS_IA    = 1;
    localparam int CLS_LD    = 2;
    localparam int CLS_SD    = 3;
    localparam int CLS_BR    = 4;
    localparam int CLS_JR    = 5;
    localparam int CLS_J     = 6;
    localparam int CLS_LUI   = 7;
    localparam int CLS_AUIPC = 8;
    localparam int CLS_FENCE = 9;
    localparam int CLS_SYS   = 10;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [10:0]     cls;
        logic [2:0]      funct3;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [31:0]     imm;
        logic            mret;
        logic            illegal;
    } entry_t;

    // Map istr[6:2] to the one-hot class; unknown opcodes give all zeros
    function automatic logic [10:0] dec_cls(input logic [4:0] op);
        logic [10:0] c;
        c = '0;
        case (op)
            5'b01100: c[CLS_RA]    = 1'b1;
            5'b00100: c[CLS_IA]    = 1'b1;
            5'b00000: c[CLS_LD]    = 1'b1;
            5'b01000: c[CLS_SD]    = 1'b1;
            5'b11000: c[CLS_BR]    = 1'b1;
            5'b11001: c[CLS_JR]    = 1'b1;
            5'b11011: c[CLS_J]     = 1'b1;
            5'b01101: c[CLS_LUI]   = 1'b1;
            5'b00101: c[CLS_AUIPC] = 1'b1;
            5'b00011: c[CLS_FENCE] = 1'b1;
            5'b11100: c[CLS_SYS]   = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    // Assemble the sign-extended immediate for the instruction's format
    function automatic logic [31:0] dec_imm(input logic [31:0] istr, input logic [10:0] cls);
        logic [31:0] imm;
        imm = '0;
        if (cls[CLS_IA] || cls[CLS_LD] || cls[CLS_JR] || cls[CLS_SYS])
            imm = {{20{istr[31]}}, istr[31:20]};
        else if (cls[CLS_SD])
            imm = {{20{istr[31]}}, istr[31:25], istr[11:7]};
        else if (cls[CLS_BR])
            imm = {{19{istr[31]}}, istr[31], istr[7], istr[30:25], istr[11:8], 1'b0};
        else if (cls[CLS_LUI] || cls[CLS_AUIPC])
            imm = {istr[31:12], 12'h000};
        else if (cls[CLS_J])
            imm = {{11{istr[31]}}, istr[31], istr[19:12], istr[20], istr[30:21], 1'b0};
        return imm;
    endfunction

`ifdef CORE_ID_DC_ILLEGAL_CHK_EN
    // Flag encodings that RV32I does not define; the entry is still queued
    function automatic logic dec_illegal(input logic [31:0] istr, input logic [10:0] cls);
        logic [6:0] f7;
        logic [2:0] f3;
        logic       ill;
        f7  = istr[31:25];
        f3  = istr[14:12];
        ill = (istr[1:0] != 2'b11) || (cls == '0);
        if (cls[CLS_RA]) begin
            if (f7 != 7'b0000000 && f7 != 7'b0100000)
                ill = 1'b1;
            if (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101)
                ill = 1'b1;
        end
        if (cls[CLS_IA]) begin
            if (f3 == 3'b001 && f7 != 7'b0000000)
                ill = 1'b1;
            if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)
                ill = 1'b1;
        end
        if (cls[CLS_LD] && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111))
            ill = 1'b1;
        if (cls[CLS_SD] && f3 >= 3'b011)
            ill = 1'b1;
        if (cls[CLS_BR] && (f3 == 3'b010 || f3 == 3'b011))
            ill = 1'b1;
        if (cls[CLS_JR] && f3 != 3'b000)
            ill = 1'b1;
        if (cls[CLS_SYS] && f3 == 3'b100)
            ill = 1'b1;
        return ill;
    endfunction
`else
    // The opcode size bits only feed the illegal check
    logic unused_istr_lo;
    assign unused_istr_lo = &{1'b0, in_istr[1:0]};
`endif

    entry_t           ent_p0;
    entry_t           mem_p1 [DEPTH];
    entry_t           head_p1;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             vld_p1;
    logic             push;
    logic             pop;

    // Stage 0: combinational decode of the instruction IF presents
    always_comb begin
        ent_p0         = '0;
        ent_p0.pc      = in_pc;
        ent_p0.cls     = dec_cls(in_istr[6:2]);
        ent_p0.funct3  = in_istr[14:12];
        ent_p0.rd      = (ent_p0.cls[CLS_SD] || ent_p0.cls[CLS_BR]) ? 5'd0 : in_istr[11:7];
        ent_p0.rs1     = in_istr[19:15];
        ent_p0.rs2     = in_istr[24:20];
        ent_p0.imm     = dec_imm(in_istr, ent_p0.cls);
        ent_p0.mret    = (in_istr == 32'h3020_0073);
`ifdef CORE_ID_DC_ILLEGAL_CHK_EN
        ent_p0.illegal = dec_illegal(in_istr, ent_p0.cls);
`else
        ent_p0.illegal = 1'b0;
`endif
    end

    assign in_ready = (count != CNT_W'(DEPTH));
    assign vld_p1   = (count != '0);
    assign push     = in_valid && in_ready && !flush;
    assign pop      = vld_p1 && out_ready && !flush;

    // Stage 1: write the decoded entry into the queue slot at wr_ptr
    always_ff @(posedge clk) begin
        if (push)
            mem_p1[wr_ptr] <= ent_p0;
    end

    // Queue control: pointers and occupancy, with flush below reset only
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // Head of queue, masked to zero while nothing is valid
    always_comb begin
        head_p1 = '0;
        if (vld_p1)
            head_p1 = mem_p1[rd_ptr];
    end

    assign out_valid   = vld_p1;
    assign out_count   = count;
    assign out_pc      = head_p1.pc;
    assign out_cls     = head_p1.cls;
    assign out_funct3  = head_p1.funct3;
    assign out_rd      = head_p1.rd;
    assign out_rs1     = head_p1.rs1;
    assign out_rs2     = head_p1.rs2;
    assign out_imm     = head_p1.imm;
    assign out_mret    = head_p1.mret;
    assign out_illegal = head_p1.illegal;

endmodule

// File: tb/tb_core_id_dc_stage.sv
// tb_core_id_dc_stage: directed bench for core_id_dc_stage with a scoreboard
// of expected decoded entries (DEPTH=2, PC_W=32).
module tb_core_id_dc_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_istr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [10:0] out_cls;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [31:0] out_imm;
    logic        out_mret;
    logic        out_illegal;
    logic [1:0]  out_count;

    localparam logic [10:0] C_RA  = 11'd1;
    localparam logic [10:0] C_IA  = 11'd2;
    localparam logic [10:0] C_SD  = 11'd8;
    localparam logic [10:0] C_BR  = 11'd16;
    localparam logic [10:0] C_LUI = 11'd128;
    localparam logic [10:0] C_SYS = 11'd1024;

`ifdef CORE_ID_DC_ILLEGAL_CHK_EN
    localparam logic ILL_ON = 1'b1;
`else
    localparam logic ILL_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [10:0] cls;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        mret;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    core_id_dc_stage #(.DEPTH(2), .PC_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_istr     (in_istr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_cls     (out_cls),
        .out_funct3  (out_funct3),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_imm     (out_imm),
        .out_mret    (out_mret),
        .out_illegal (out_illegal),
        .out_count   (out_count)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] pc, input logic [10:0] cls,
                                input logic [2:0] f3, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic mret,
                                input logic ill);
        exp_t e;
        e.pc = pc; e.cls = cls; e.f3 = f3; e.rd = rd; e.rs1 = rs1;
        e.rs2 = rs2; e.imm = imm; e.mret = mret; e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction for one cycle; queue its expectation if accepted
    task automatic push(input logic [31:0] istr, input logic [31:0] pc, input exp_t e);
        in_valid = 1'b1;
        in_istr  = istr;
        in_pc    = pc;
        if (in_ready && !flush)
            sb.push_back(e);
        step();
        in_valid = 1'b0;
    endtask

    // Compare the DUT head against the oldest scoreboard entry
    task automatic check_head(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb[0];
        chk({tag, "_pc"},  out_pc,              e.pc);
        chk({tag, "_cls"}, 32'(out_cls),        32'(e.cls));
        chk({tag, "_f3"},  32'(out_funct3),     32'(e.f3));
        chk({tag, "_rd"},  32'(out_rd),         32'(e.rd));
        chk({tag, "_rs1"}, 32'(out_rs1),        32'(e.rs1));
        chk({tag, "_rs2"}, 32'(out_rs2),        32'(e.rs2));
        chk({tag, "_imm"}, out_imm,             e.imm);
        chk({tag, "_mret"}, 32'(out_mret),      32'(e.mret));
        chk({tag, "_ill"}, 32'(out_illegal),    32'(e.ill));
    endtask

    // Check the head, then consume it with a one-cycle out_ready pulse
    task automatic pop_check(input string tag);
        check_head(tag);
        if (sb.size() != 0)
            sb.delete(0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_istr   = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state, outputs masked
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready),  32'd1);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_pc",    out_pc,         32'd0);
        chk("rst_imm",   out_imm,        32'd0);
        chk("rst_cls",   32'(out_cls),   32'd0);

        // addi x1,x0,5
        push(32'h0050_0093, 32'h100, mk(32'h100, C_IA, 3'd0, 5'd1, 5'd0, 5'd5, 32'h5, 1'b0, 1'b0));
        chk("addi_count", 32'(out_count), 32'd1);
        pop_check("addi");
        chk("empty_count", 32'(out_count), 32'd0);
        chk("empty_valid", 32'(out_valid), 32'd0);

        // sw x2,8(x1) then beq x0,x0,-4 back to back
        push(32'h0020_A423, 32'h104, mk(32'h104, C_SD, 3'd2, 5'd0, 5'd1, 5'd2, 32'h8, 1'b0, 1'b0));
        push(32'hFE00_0EE3, 32'h108, mk(32'h108, C_BR, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0, 1'b0));
        chk("full_count", 32'(out_count), 32'd2);
        chk("full_ready", 32'(in_ready),  32'd0);
        pop_check("sw");
        pop_check("beq");

        // Fill, stall, offer a third instruction while full
        push(32'h0050_0093, 32'h200, mk(32'h200, C_IA, 3'd0, 5'd1, 5'd0, 5'd5, 32'h5, 1'b0, 1'b0));
        push(32'h0020_81B3, 32'h204, mk(32'h204, C_RA, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b0));
        in_valid = 1'b1;
        in_istr  = 32'h1234_52B7;
        in_pc    = 32'h208;
        step();
        step();
        chk("stall_count", 32'(out_count), 32'd2);
        chk("stall_ready", 32'(in_ready),  32'd0);
        check_head("stall_head");
        pop_check("stall_pop");
        in_valid = 1'b0;
        chk("nopt_count", 32'(out_count), 32'd1);
        chk("nopt_ready", 32'(in_ready),  32'd1);
        pop_check("stall_second");
        chk("drain_count", 32'(out_count), 32'd0);
        chk("drain_pc_mask", out_pc, 32'd0);

        // Flush while full with a concurrent in_valid
        push(32'h0050_0093, 32'h300, mk(32'h300, C_IA, 3'd0, 5'd1, 5'd0, 5'd5, 32'h5, 1'b0, 1'b0));
        push(32'h0020_81B3, 32'h304, mk(32'h304, C_RA, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b0));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_istr  = 32'h3020_0073;
        in_pc    = 32'h308;
        sb.delete();
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_count", 32'(out_count), 32'd0);

        // Flush with one entry, in_ready high, in_valid and out_ready asserted
        push(32'h0050_0093, 32'h310, mk(32'h310, C_IA, 3'd0, 5'd1, 5'd0, 5'd5, 32'h5, 1'b0, 1'b0));
        flush     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_istr   = 32'h3020_0073;
        in_pc     = 32'h314;
        sb.delete();
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("flush2_valid", 32'(out_valid), 32'd0);
        chk("flush2_count", 32'(out_count), 32'd0);

        // lui x5,0x12345 after flush: the flushed instruction must not show
        push(32'h1234_52B7, 32'h320, mk(32'h320, C_LUI, 3'd5, 5'd5, 5'd8, 5'd3, 32'h1234_5000, 1'b0, 1'b0));
        pop_check("lui");

        // mret, then add pushed in the same cycle that mret is popped
        push(32'h3020_0073, 32'h400, mk(32'h400, C_SYS, 3'd0, 5'd0, 5'd0, 5'd2, 32'h302, 1'b1, 1'b0));
        check_head("mret");
        sb.delete(0);
        in_valid  = 1'b1;
        in_istr   = 32'h0020_81B3;
        in_pc     = 32'h404;
        if (in_ready)
            sb.push_back(mk(32'h404, C_RA, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b0));
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("pushpop_count", 32'(out_count), 32'd1);
        pop_check("add");

        // Illegal encodings: unknown opcode and sub-style funct7 with funct3=001
        push(32'h0000_007F, 32'h500, mk(32'h500, 11'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, ILL_ON));
        push(32'h4020_91B3, 32'h504, mk(32'h504, C_RA, 3'd1, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, ILL_ON));
        pop_check("ill_op");
        pop_check("ill_f7");
        chk("final_count", 32'(out_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
